// File: rtl/calc_stack.sv
// Operand stack for the RPN calculator: the top element lives in a register, the rest in a synchronous-read RAM.
// Optional macro CALC_STACK_ERR_AUTOCLEAR_EN: error clears after any command accepted without fault.
module calc_stack #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 replace,
  input  logic [WIDTH-1:0]     in_num,
  output logic [WIDTH-1:0]     top,
  output logic [ADDR_BITS-1:0] size,
  output logic                 error,
  output logic                 out_vld
);

  localparam logic [ADDR_BITS-1:0] CAP = '1;
`ifdef CALC_STACK_ERR_AUTOCLEAR_EN
  localparam bit AUTOCLEAR = 1'b1;
`else
  localparam bit AUTOCLEAR = 1'b0;
`endif

  typedef enum logic [1:0] {READY, RD_ISSUE, RD_LOAD} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     top_q, top_d;
  logic [ADDR_BITS-1:0] size_q, size_d;
  logic                 err_q, err_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]     rd_data_q;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [1:0]           n_cmd;
  logic                 cmd_fault, cmd_ok;

  logic [WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

  assign n_cmd = {1'b0, push} + {1'b0, pop} + {1'b0, replace};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= READY;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:    if (n_cmd == 2'd1 && pop && size_q > ADDR_BITS'(1)) state_d = RD_ISSUE;
      RD_ISSUE: state_d = RD_LOAD;
      RD_LOAD:  state_d = READY;
      default:  state_d = READY;
    endcase
  end

  // Output logic
  always_comb begin
    out_vld = (state_q == READY);
  end

  // Datapath: full/empty checks come before every size update so size never wraps.
  always_comb begin
    top_d     = top_q;
    size_d    = size_q;
    rd_addr_d = rd_addr_q;
    wr_en     = 1'b0;
    wr_addr   = size_q - ADDR_BITS'(1);
    cmd_fault = 1'b0;
    cmd_ok    = 1'b0;
    if (state_q == READY) begin
      if (n_cmd > 2'd1) begin
        cmd_fault = 1'b1;
      end else if (push) begin
        if (size_q == CAP) begin
          cmd_fault = 1'b1;
        end else begin
          wr_en  = (size_q != '0);
          top_d  = in_num;
          size_d = size_q + ADDR_BITS'(1);
          cmd_ok = 1'b1;
        end
      end else if (replace) begin
        if (size_q == '0) begin
          cmd_fault = 1'b1;
        end else begin
          top_d  = in_num;
          cmd_ok = 1'b1;
        end
      end else if (pop) begin
        if (size_q == '0) begin
          cmd_fault = 1'b1;
        end else begin
          size_d = size_q - ADDR_BITS'(1);
          cmd_ok = 1'b1;
          if (size_q == ADDR_BITS'(1)) top_d = '0;
          else                         rd_addr_d = size_q - ADDR_BITS'(2);
        end
      end
    end else begin
      cmd_fault = (n_cmd != 2'd0);
      if (state_q == RD_LOAD) top_d = rd_data_q;
    end
    err_d = cmd_fault | (err_q & ~(AUTOCLEAR & cmd_ok));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q     <= '0;
      size_q    <= '0;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      top_q     <= top_d;
      size_q    <= size_d;
      err_q     <= err_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Block RAM, registered read. A pop's read is issued two edges after the
  // preceding push's write, so a just-pushed word is always already stored.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= top_q;
    rd_data_q <= mem[rd_addr_q];
  end

  assign top   = top_q;
  assign size  = size_q;
  assign error = err_q;

endmodule

// File: tb/tb_calc_stack.sv
// Directed-vector bench for calc_stack; inputs change and outputs are sampled on the falling edge.
module tb_calc_stack;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 5;
  localparam int CAP       = (2**ADDR_BITS) - 1;
`ifdef CALC_STACK_ERR_AUTOCLEAR_EN
  localparam logic [31:0] ERR_AFTER_GOOD = 32'd0;
`else
  localparam logic [31:0] ERR_AFTER_GOOD = 32'd1;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 push = 1'b0, pop = 1'b0, replace = 1'b0;
  logic [WIDTH-1:0]     in_num = '0;
  logic [WIDTH-1:0]     top;
  logic [ADDR_BITS-1:0] size;
  logic                 error, out_vld;

  int n_checks = 0;
  int n_fail   = 0;

  calc_stack #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .replace(replace),
    .in_num(in_num), .top(top), .size(size), .error(error), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // All command tasks start and end on a falling edge, so they can run back to back.
  task automatic do_reset();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
  endtask

  task automatic do_cmd(input logic p, input logic o, input logic r, input logic [WIDTH-1:0] v);
    push = p; pop = o; replace = r; in_num = v;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; replace = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] v);  do_cmd(1'b1, 1'b0, 1'b0, v);  endtask
  task automatic do_pop();                            do_cmd(1'b0, 1'b1, 1'b0, '0); endtask

  // Counts out_vld-low cycles up to a bound and checks the stall length.
  task automatic wait_ready(input string tag, input int exp_low);
    int n = 0;
    while (!out_vld && n < 10) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp_low));
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    do_reset();
    check("rst_top", top, 0);
    check("rst_size", 32'(size), 0);
    check("rst_err", 32'(error), 0);
    check("rst_vld", 32'(out_vld), 1);

    do_push(32'h5);
    check("push5_vld", 32'(out_vld), 1);
    do_push(32'h7);
    check("push7_top", top, 7);
    check("push7_size", 32'(size), 2);
    check("push7_vld", 32'(out_vld), 1);
    check("push7_err", 32'(error), 0);

    do_pop();
    check("pop1_size_early", 32'(size), 1);
    check("pop1_vld_low", 32'(out_vld), 0);
    wait_ready("pop1_stall", 2);
    check("pop1_top", top, 5);
    do_pop();
    wait_ready("pop2_stall", 0);
    check("pop2_size", 32'(size), 0);
    check("pop2_top", top, 0);

    do_pop();
    check("empty_pop_err", 32'(error), 1);
    check("empty_pop_size", 32'(size), 0);
    do_cmd(1'b0, 1'b0, 1'b1, 32'h1234);
    check("empty_repl_err", 32'(error), 1);
    check("empty_repl_top", top, 0);
    check("empty_repl_size", 32'(size), 0);
    do_push(32'h9);
    check("good_push_err", 32'(error), ERR_AFTER_GOOD);
    check("good_push_top", top, 9);
    do_cmd(1'b0, 1'b0, 1'b1, 32'h55);
    check("repl_top", top, 32'h55);
    check("repl_size", 32'(size), 1);

    do_reset();
    for (int k = 1; k <= CAP; k++) do_push(32'(k));
    check("full_size", 32'(size), CAP);
    check("full_err", 32'(error), 0);
    do_push(32'hDEAD);
    check("ovf_err", 32'(error), 1);
    check("ovf_size", 32'(size), CAP);
    check("ovf_top", top, CAP);
    for (int k = CAP; k >= 1; k--) begin
      check($sformatf("drain_top_%0d", k), top, 32'(k));
      do_pop();
      wait_ready($sformatf("drain_stall_%0d", k), (k > 1) ? 2 : 0);
    end
    check("drain_size", 32'(size), 0);

    do_reset();
    do_push(32'hA);
    do_push(32'hB);
    do_pop();
    wait_ready("hazard_stall", 2);
    check("hazard_top", top, 32'hA);
    check("hazard_size", 32'(size), 1);

    do_reset();
    do_pop();
    do_push(32'h1); do_push(32'h2); do_push(32'h3);
    do_pop();
    check("midrd_vld_low", 32'(out_vld), 0);
    do_reset();
    check("midrd_size", 32'(size), 0);
    check("midrd_top", top, 0);
    check("midrd_vld", 32'(out_vld), 1);
    check("midrd_err", 32'(error), 0);

    do_push(32'h4);
    do_cmd(1'b1, 1'b1, 1'b0, 32'h8);
    check("multi_err", 32'(error), 1);
    check("multi_size", 32'(size), 1);
    check("multi_top", top, 4);

    do_push(32'h6);
    do_pop();
    do_push(32'h77);
    check("busy_cmd_err", 32'(error), 1);
    wait_ready("busy_stall", 1);
    check("busy_size", 32'(size), 1);
    check("busy_top", top, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
